sc_stream_decoder: RTL and testbench

Stochastic-to-binary converter: counts the ones in a unipolar stochastic bitstream over a fixed window of LENGTH accepted bits and presents the count as a binary value. It is the decode end of the stochastic number path: the bit-reversed counter and comparator generate streams, and this block turns result streams back into binary for readout.

---
 rtl/sc_pkg.sv | 36 +++
 rtl/sc_window_counter.sv | 47 ++++
 rtl/sc_stream_decoder.sv | 161 ++++++++++++++++
 tb/tb_sc_stream_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-computing number path: the decoder FSM
// state type, a constant clog2 helper and the width rule for ones counts.
// No ports (package).
// -----------------------------------------------------------------------------
package sc_pkg;

    // Decoder control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sc_state_e;

    // Ceiling log2, usable in parameter and localparam expressions.
    // Returns 0 for values of 0 or 1.
    function automatic int sc_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Width of a ones count for N-bit binary numbers. The extra bit lets a
    // window of all ones (count = 2^N) be represented without wrapping.
    function automatic int sc_count_width(input int n);
        return n + 1;
    endfunction

endpackage : sc_pkg

// File: rtl/sc_window_counter.sv
// -----------------------------------------------------------------------------
// sc_window_counter
// Sample counter for one decode window. It counts enabled cycles from zero and
// raises a terminal flag while the count equals LENGTH-1, which is the moment
// the next accepted bit is the last one in the window.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset (count -> 0)
//   clr   in   synchronous clear, takes priority over en
//   en    in   count enable (one accepted sample)
//   last  out  count == LENGTH-1
// -----------------------------------------------------------------------------
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int LENGTH = 1024,
    parameter int W      = (sc_clog2(LENGTH + 1) < 1) ? 1 : sc_clog2(LENGTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [W-1:0] LAST_VALUE = W'(LENGTH - 1);
    localparam logic [W-1:0] ONE        = W'(1);

    logic [W-1:0] count_r;

    // Sample count register: clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == LAST_VALUE);

endmodule : sc_window_counter

// File: rtl/sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// sc_stream_decoder
// Stochastic-to-binary converter. Counts the ones in a unipolar stochastic
// bitstream over a window of LENGTH accepted bits and holds the count for a
// valid/ready sink.
//
// Parameters:
//   N       binary width (LENGTH <= 2^N)
//   LENGTH  window length in accepted bits, 1..2^N
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a window (IDLE, or HOLD with out_ready)
//   abort      in   drop the window and return to IDLE
//   in_valid   in   in_bit is valid
//   in_bit     in   stochastic stream bit
//   in_ready   out  a bit is accepted this cycle when in_valid is high
//   out_valid  out  out_count holds a completed window result
//   out_ready  in   sink accepts out_count
//   out_count  out  ones in the window, 0..LENGTH (N+1 bits)
//   busy       out  window accumulation in progress
// -----------------------------------------------------------------------------
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int N      = 10,
    parameter int LENGTH = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_count,
    output logic         busy
);

    localparam int CW = sc_count_width(N);

    sc_state_e       state_r;
    sc_state_e       next_state_s;
    logic            clr_s;
    logic            accept_s;
    logic            finish_s;
    logic            last_s;
    logic [CW-1:0]   ones_r;
    logic [CW-1:0]   out_count_r;
    logic            out_valid_r;
    logic [CW-1:0]   in_bit_ext_s;

    // in_ready is a pure decode of the state register, so accept has no
    // combinational dependence on in_ready's own inputs.
    assign accept_s     = (state_r == ACCUM) && in_valid;
    assign finish_s     = accept_s && last_s && !abort;
    assign in_bit_ext_s = CW'(in_bit);

    sc_window_counter #(
        .LENGTH (LENGTH)
    ) u_window_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .en   (accept_s && !abort),
        .last (last_s)
    );

    // Next-state and counter-clear decode; abort overrides every state.
    always_comb begin
        next_state_s = state_r;
        clr_s        = 1'b0;
        if (abort) begin
            next_state_s = IDLE;
            clr_s        = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        next_state_s = ACCUM;
                        clr_s        = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (accept_s && last_s) begin
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready && start) begin
                        next_state_s = ACCUM;
                        clr_s        = 1'b1;
                    end else if (out_ready) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = HOLD;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    clr_s        = 1'b1;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Ones accumulator for the current window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_r <= '0;
        end else if (clr_s) begin
            ones_r <= '0;
        end else if (accept_s && in_bit) begin
            ones_r <= ones_r + in_bit_ext_s;
        end else begin
            ones_r <= ones_r;
        end
    end

    // Result register: captures the final count including the last bit, and
    // keeps its value across abort so a later readout is not disturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count_r <= '0;
        end else if (finish_s) begin
            out_count_r <= ones_r + in_bit_ext_s;
        end else begin
            out_count_r <= out_count_r;
        end
    end

    // out_valid register, high exactly while the FSM sits in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (next_state_s == HOLD);
        end
    end

    assign in_ready  = (state_r == ACCUM);
    assign busy      = (state_r == ACCUM);
    assign out_valid = out_valid_r;
    assign out_count = out_count_r;

endmodule : sc_stream_decoder

// File: tb/tb_sc_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sc_stream_decoder
// Directed bench for sc_stream_decoder. Three instances share the clock, reset
// and stream inputs and each has its own start:
//   a: N=3,  LENGTH=8
//   b: N=10, LENGTH=1024 (defaults)
//   c: N=1,  LENGTH=1
// Only the instance that was started leaves IDLE; the others ignore the
// shared stream.
// -----------------------------------------------------------------------------
module tb_sc_stream_decoder;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        start_c;
    logic        abort;
    logic        in_valid;
    logic        in_bit;
    logic        out_ready;

    logic        in_ready_a;
    logic        out_valid_a;
    logic [3:0]  out_count_a;
    logic        busy_a;
    logic        in_ready_b;
    logic        out_valid_b;
    logic [10:0] out_count_b;
    logic        busy_b;
    logic        in_ready_c;
    logic        out_valid_c;
    logic [1:0]  out_count_c;
    logic        busy_c;

    int          n_checks;
    int          n_fail;

    sc_stream_decoder #(.N(3), .LENGTH(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_count (out_count_a),
        .busy      (busy_a)
    );

    sc_stream_decoder u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_count (out_count_b),
        .busy      (busy_b)
    );

    sc_stream_decoder #(.N(1), .LENGTH(1)) u_dut_c (
        .clk       (clk),
        .rst       (rst),
        .start     (start_c),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready_c),
        .out_valid (out_valid_c),
        .out_ready (out_ready),
        .out_count (out_count_c),
        .busy      (busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; afterwards we sit 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid bit for exactly one cycle.
    task automatic push(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [31:0] stall_mask;
        int          k;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        start_c   = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check_eq("rst_in_ready_a",  32'(in_ready_a),  32'd0);
        check_eq("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        check_eq("rst_busy_a",      32'(busy_a),      32'd0);
        check_eq("rst_count_a",     32'(out_count_a), 32'd0);
        check_eq("rst_in_ready_b",  32'(in_ready_b),  32'd0);
        check_eq("rst_count_b",     32'(out_count_b), 32'd0);
        check_eq("rst_out_valid_c", 32'(out_valid_c), 32'd0);

        // All ones, LENGTH=8.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("ones_in_ready", 32'(in_ready_a), 32'd1);
        check_eq("ones_busy",     32'(busy_a),     32'd1);
        for (int i = 0; i < 8; i++) begin
            push(1'b1);
            if (i == 6) check_eq("ones_valid_early", 32'(out_valid_a), 32'd0);
        end
        check_eq("ones_out_valid", 32'(out_valid_a), 32'd1);
        check_eq("ones_count",     32'(out_count_a), 32'd8);
        check_eq("ones_busy_hold", 32'(busy_a),      32'd0);

        // Backpressure: HOLD for 10 cycles with out_ready low.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp_count",    32'(out_count_a), 32'd8);
            check_eq("bp_in_ready", 32'(in_ready_a),  32'd0);
        end
        check_eq("bp_out_valid", 32'(out_valid_a), 32'd1);

        // Back-to-back: out_ready and start together in HOLD.
        out_ready = 1'b1;
        start_a   = 1'b1;
        tick();
        out_ready = 1'b0;
        start_a   = 1'b0;
        check_eq("b2b_in_ready",  32'(in_ready_a),  32'd1);
        check_eq("b2b_out_valid", 32'(out_valid_a), 32'd0);
        pat = 8'b0000_0111;
        for (int i = 0; i < 8; i++) push(pat[i]);
        check_eq("b2b_out_valid2", 32'(out_valid_a), 32'd1);
        check_eq("b2b_count",      32'(out_count_a), 32'd3);
        handshake();
        check_eq("b2b_idle_valid", 32'(out_valid_a), 32'd0);
        check_eq("b2b_idle_ready", 32'(in_ready_a),  32'd0);

        // Stalls: 8 accepts holding 5 ones, in_valid toggling.
        pat        = 8'b1010_1101;
        stall_mask = 32'b1011_0010_1100_1101_0110_1001_1010_0101;
        start_a    = 1'b1;
        tick();
        start_a    = 1'b0;
        k          = 0;
        for (int cyc = 0; cyc < 32 && k < 8; cyc++) begin
            in_valid = stall_mask[cyc];
            in_bit   = pat[k[2:0]];
            tick();
            if (stall_mask[cyc]) k = k + 1;
            check_eq("stall_valid_track", 32'(out_valid_a), (k == 8) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check_eq("stall_accepts", 32'(k),          32'd8);
        check_eq("stall_count",   32'(out_count_a), 32'd5);
        handshake();

        // Abort after 4 of 8 bits.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_in_ready",  32'(in_ready_a),  32'd0);
        check_eq("abort_busy",      32'(busy_a),      32'd0);
        check_eq("abort_out_valid", 32'(out_valid_a), 32'd0);
        check_eq("abort_keep_count", 32'(out_count_a), 32'd5);
        tick();
        check_eq("abort_stays_idle", 32'(out_valid_a), 32'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) push(1'b1);
        check_eq("abort_next_count", 32'(out_count_a), 32'd8);
        check_eq("abort_next_valid", 32'(out_valid_a), 32'd1);
        handshake();

        // abort and start together in IDLE.
        abort   = 1'b1;
        start_a = 1'b1;
        tick();
        abort   = 1'b0;
        start_a = 1'b0;
        check_eq("abort_start_ready", 32'(in_ready_a), 32'd0);
        check_eq("abort_start_busy",  32'(busy_a),     32'd0);

        // Alternating 1024-bit window on the default instance.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check_eq("alt_in_ready", 32'(in_ready_b), 32'd1);
        for (int i = 0; i < 1024; i++) push((i % 2) == 0);
        check_eq("alt_out_valid", 32'(out_valid_b), 32'd1);
        check_eq("alt_count",     32'(out_count_b), 32'd512);
        handshake();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 1024; i++) push(1'b0);
        check_eq("zero_out_valid", 32'(out_valid_b), 32'd1);
        check_eq("zero_count",     32'(out_count_b), 32'd0);
        handshake();

        // Asynchronous reset mid-ACCUM.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_acc_in_ready", 32'(in_ready_a),  32'd0);
        check_eq("rst_acc_busy",     32'(busy_a),      32'd0);
        check_eq("rst_acc_count",    32'(out_count_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_acc_idle", 32'(in_ready_a), 32'd0);

        // Asynchronous reset mid-HOLD.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) push(1'b1);
        check_eq("rst_hold_pre_valid", 32'(out_valid_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_hold_valid", 32'(out_valid_a), 32'd0);
        check_eq("rst_hold_count", 32'(out_count_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // LENGTH=1.
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check_eq("len1_in_ready", 32'(in_ready_c), 32'd1);
        push(1'b1);
        check_eq("len1_out_valid", 32'(out_valid_c), 32'd1);
        check_eq("len1_count",     32'(out_count_c), 32'd1);
        check_eq("len1_in_ready2", 32'(in_ready_c),  32'd0);
        handshake();
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        push(1'b0);
        check_eq("len1_zero_count", 32'(out_count_c), 32'd0);
        check_eq("len1_zero_valid", 32'(out_valid_c), 32'd1);
        handshake();
        check_eq("len1_idle_valid", 32'(out_valid_c), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sc_stream_decoder
